ex_div: RTL and testbench
=========================

# ex_div

Multi-cycle 32-bit integer divider for the EX stage of the five-stage MIPS pipeline (DIV/DIVU). It sits directly upstream of the stall controller and drives that controller's EX stall request for as long as a division is in flight. This freezes PC, IF/ID, ID/EX and EX. On completion it delivers quotient (LO) and remainder (HI) to the EX/MEM path.

## Interface
- `WIDTH`, 32, operand and result width.
- `clk` in 1: pipeline clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `clr` in 1: synchronous pipeline flush; aborts any division in progress.
- `div_start` in 1: the instruction in EX is DIV/DIVU; held high while EX is frozen.
- `div_signed` in 1: 1 = DIV, 0 = DIVU; sampled with `div_start` in IDLE.
- `dividend` in WIDTH: rs operand; sampled in IDLE.
- `divisor` in WIDTH: rt operand; sampled in IDLE.
- `stall_req` out 1: to the stall controller's EX stall request input; combinational.
- `result_valid` out 1: registered; high exactly one cycle (DONE).
- `lo` out WIDTH: registered quotient.
- `hi` out WIDTH: registered remainder.

## Operation
- **States:** IDLE, BUSY, DONE.
- **IDLE:**
  - On `div_start & !clr`, latch operands and the signed flag.
  - For signed operation, convert both operands to magnitudes and record `q_neg = sign(dividend)^sign(divisor)` and `r_neg = sign(dividend)`.
  - If `divisor == 0`, go to DONE with `lo = {WIDTH{1}}` and `hi = dividend`.
  - Otherwise go to BUSY with iteration counter 0 and partial remainder 0.
- **BUSY:**
  - Each cycle performs one restoring step: shift {rem, quo} left by 1, trial-subtract the divisor magnitude, keep the result if non-negative, and set the quotient LSB accordingly.
  - The counter (clog2(WIDTH)+1 bits) increments each step.
  - After step WIDTH, apply sign fix-up (two's-complement negate quotient if `q_neg`, remainder if `r_neg`), load `lo`/`hi`, and go to DONE.
- **DONE:** `result_valid = 1`, then go to IDLE unconditionally. The still-asserted `div_start` of the finishing instruction is ignored.
- **`stall_req`:** `div_start & !clr & (state != DONE)`. Stalling therefore begins in the same cycle the instruction enters EX and drops in the DONE cycle, so EX advances exactly then.
- **`clr`:** has priority over everything except `rst_n`. From any state it goes to IDLE, forces `result_valid = 0` on the next edge, and holds `lo`/`hi` unchanged.
- **Arithmetic:** all internal datapath is WIDTH+1 bits for the trial subtract; results wrap to WIDTH.
  - Signed INT_MIN / -1 gives `lo = 0x80000000`, `hi = 0`.
  - Unsigned operands never negate.
- **Reset values:** state IDLE, counter 0, `lo = 0`, `hi = 0`, `result_valid = 0`, `stall_req = 0` while `div_start` is low.

## Timing
- Start cycle T0 (IDLE), then BUSY T1..T32, then DONE at T33.
- `stall_req` is high T0..T32 (33 cycles) and low at T33.
- Divide-by-zero: DONE at T1, `stall_req` high only at T0.
- `lo`/`hi` are valid from T33 and held until the next completion.
- Back-to-back divides: the second `div_start` is seen at T34 in IDLE. There is no bubble beyond DONE.
- `rst_n` low mid-BUSY: immediate return to IDLE and zeroed outputs, with no waiting for the clock.

## Structure
- Shared package holds the `div_state_t` encoding (IDLE/BUSY/DONE), `DIV_WIDTH = 32`, and the `DIV_ITER` constant.
- One natural sub-module, `div_step`: a combinational single restoring iteration (rem_in, quo_in, divisor → rem_out, quo_out), instantiated once and iterated by the FSM.

## Test plan
- **Unsigned 100 / 7:** `div_start`, `div_signed = 0` → `stall_req` high 33 cycles, `result_valid` at T33, `lo = 14`, `hi = 2`.
- **Signed -100 / 7:** `lo = 0xFFFFFFF2` (-14), `hi = 0xFFFFFFFE` (-2). Also 0x80000000 / 0xFFFFFFFF signed → `lo = 0x80000000`, `hi = 0`.
- **Divisor 0, dividend 0x1234:** DONE at T1, `lo = 0xFFFFFFFF`, `hi = 0x1234`, `stall_req` high one cycle.
- **`clr` at T10 of a divide:** `stall_req` low in the same cycle, IDLE next edge, no `result_valid`, `lo`/`hi` keep prior values. A fresh `div_start` at T12 completes normally.
- **`rst_n` pulsed low mid-BUSY (asynchronous, between edges):** outputs zero immediately, state IDLE.
- **Back-to-back DIVU 0xFFFFFFFF / 1 then 10 / 3:** `result_valid` at T33 and T67, results 0xFFFFFFFF/0 then 3/1, with the start held through T33 not retriggering.

Source files
------------

// File: rtl/ex_div_pkg.sv
// ex_div_pkg: shared definitions for the EX-stage multi-cycle divider.
//   DIV_WIDTH   - operand / result width of the MIPS datapath
//   DIV_ITER    - restoring iterations per division (one quotient bit each)
//   div_state_t - FSM state encoding (IDLE / BUSY / DONE)
package ex_div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_ITER  = DIV_WIDTH;

  typedef logic [1:0] div_state_t;

  localparam div_state_t S_IDLE = 2'd0;
  localparam div_state_t S_BUSY = 2'd1;
  localparam div_state_t S_DONE = 2'd2;

endpackage

// File: rtl/ex_div_step.sv
// div_step: one combinational restoring-division iteration.
//   rem_in   - partial remainder (always < divisor)
//   quo_in   - remaining dividend bits / quotient bits built so far
//   divisor  - divisor magnitude
//   rem_out  - updated partial remainder
//   quo_out  - quo_in shifted left with the new quotient bit in the LSB
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff_lo;
  logic             borrow_lo;
  logic             fits;

  assign shifted = {rem_in, quo_in[WIDTH-1]};

  // The trial subtract is WIDTH+1 bits wide. When shifted[WIDTH] is set the
  // shifted remainder exceeds any WIDTH-bit divisor, so the subtract always
  // succeeds and its true result still fits in the low WIDTH bits.
  assign {borrow_lo, diff_lo} = {1'b0, shifted[WIDTH-1:0]} - {1'b0, divisor};
  assign fits    = shifted[WIDTH] | ~borrow_lo;

  assign rem_out = fits ? diff_lo : shifted[WIDTH-1:0];
  assign quo_out = {quo_in[WIDTH-2:0], fits};

endmodule

// File: rtl/ex_div.sv
// ex_div: multi-cycle 32-bit DIV/DIVU unit for the EX stage.
//   clk, rst_n         - pipeline clock, asynchronous active-low reset
//   clr                - synchronous flush; aborts any division in flight
//   div_start          - EX holds a DIV/DIVU (kept high while EX is frozen)
//   div_signed         - 1 = DIV, 0 = DIVU (sampled with div_start in IDLE)
//   dividend, divisor  - rs / rt operands (sampled in IDLE)
//   stall_req          - combinational EX stall request to the stall controller
//   result_valid       - one-cycle pulse in DONE
//   lo, hi             - registered quotient / remainder, held until next result
module ex_div
  import ex_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             div_start,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             stall_req,
  output logic             result_valid,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             valid_q, valid_d;

  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_quo;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .divisor (dvsr_q),
    .rem_out (step_rem),
    .quo_out (step_quo)
  );

  // DONE drops the request so EX advances in exactly that cycle; the start
  // still held by the finishing instruction is deliberately ignored there.
  assign stall_req = div_start & ~clr & (state_q != S_DONE);

  always_comb begin
    // NOTE: every _d gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvsr_d  = dvsr_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    valid_d = 1'b0;

    if (clr) begin
      // Flush: back to IDLE, no result pulse, lo/hi untouched.
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (div_start) begin
            q_neg_d = div_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            r_neg_d = div_signed & dividend[WIDTH-1];
            quo_d   = (div_signed && dividend[WIDTH-1]) ? -dividend : dividend;
            dvsr_d  = (div_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
            rem_d   = '0;
            cnt_d   = '0;
            if (divisor == '0) begin
              lo_d    = '1;
              hi_d    = dividend;
              valid_d = 1'b1;
              state_d = S_DONE;
            end else begin
              state_d = S_BUSY;
            end
          end
        end

        S_BUSY: begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_STEP) begin
            // Sign fix-up on the final step's outputs; negation wraps, so
            // INT_MIN / -1 yields INT_MIN with remainder 0.
            lo_d    = q_neg_q ? -step_quo : step_quo;
            hi_d    = r_neg_q ? -step_rem : step_rem;
            valid_d = 1'b1;
            state_d = S_DONE;
          end
        end

        S_DONE:  state_d = S_IDLE;

        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvsr_q  <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvsr_q  <= dvsr_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      valid_q <= valid_d;
    end
  end

  assign result_valid = valid_q;
  assign lo           = lo_q;
  assign hi           = hi_q;

endmodule

// File: tb/tb_ex_div.sv
// tb_ex_div: self-checking bench for ex_div. Directed cases (unsigned,
// signed, overflow, divide-by-zero, flush, async reset, back-to-back) followed
// by randomized divides against an arithmetic reference model.
module tb_ex_div;
  import ex_div_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        div_start = 1'b0;
  logic        div_signed = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        stall_req;
  logic        result_valid;
  logic [31:0] lo;
  logic [31:0] hi;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_lo = '0;
  logic [31:0] last_hi = '0;

  ex_div dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (clr),
    .div_start    (div_start),
    .div_signed   (div_signed),
    .dividend     (dividend),
    .divisor      (divisor),
    .stall_req    (stall_req),
    .result_valid (result_valid),
    .lo           (lo),
    .hi           (hi)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: MIPS DIV/DIVU semantics via 64-bit arithmetic (truncating
  // division, remainder takes the dividend's sign), divide-by-zero rule.
  function automatic void model(input logic sgn, input logic [31:0] a,
                                input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r);
    longint sa, sb, lq, lr;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
      return;
    end
    sa = sgn ? longint'($signed(a)) : longint'({32'd0, a});
    sb = sgn ? longint'($signed(b)) : longint'({32'd0, b});
    lq = sa / sb;
    lr = sa % sb;
    q  = lq[31:0];
    r  = lr[31:0];
  endfunction

  // Called just after a rising edge (cycle T0). Returns just after the edge
  // that ends DONE, i.e. at T(lat+1) in IDLE. With keep_start the start line
  // stays high so the next call forms a back-to-back pair.
  task automatic do_div(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input bit keep_start);
    logic [31:0] eq, er;
    int lat, stalls, exp_lat;
    model(sgn, a, b, eq, er);
    exp_lat    = (b == 32'd0) ? 1 : DIV_ITER + 1;
    div_start  = 1'b1;
    div_signed = sgn;
    dividend   = a;
    divisor    = b;
    lat    = 0;
    stalls = 0;
    while (!result_valid && lat < 40) begin
      @(negedge clk);
      if (stall_req) stalls++;
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_stall_cycles"}, 32'(stalls), 32'(exp_lat));
    check({tag, "_valid"}, {31'd0, result_valid}, 32'd1);
    check({tag, "_stall_done"}, {31'd0, stall_req}, 32'd0);
    check({tag, "_lo"}, lo, eq);
    check({tag, "_hi"}, hi, er);
    last_lo = eq;
    last_hi = er;
    @(posedge clk);
    #1;
    check({tag, "_valid_drop"}, {31'd0, result_valid}, 32'd0);
    if (!keep_start) div_start = 1'b0;
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rs;

    // Reset state.
    #2;
    check("rst_lo", lo, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_valid", {31'd0, result_valid}, 32'd0);
    check("rst_stall", {31'd0, stall_req}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed arithmetic.
    do_div("divu_100_7", 1'b0, 32'd100, 32'd7, 1'b0);
    do_div("div_m100_7", 1'b1, 32'hFFFF_FF9C, 32'd7, 1'b0);
    check("div_m100_7_lo_abs", lo, 32'hFFFF_FFF2);
    check("div_m100_7_hi_abs", hi, 32'hFFFF_FFFE);
    do_div("div_intmin_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("div_intmin_m1_lo_abs", lo, 32'h8000_0000);
    do_div("div_by_zero", 1'b0, 32'h0000_1234, 32'd0, 1'b0);
    check("div_by_zero_lo_abs", lo, 32'hFFFF_FFFF);
    do_div("divu_77_5", 1'b0, 32'd77, 32'd5, 1'b0);

    // Flush at T10: stall drops the same cycle, no result, lo/hi held.
    div_start  = 1'b1;
    div_signed = 1'b0;
    dividend   = 32'd5000;
    divisor    = 32'd3;
    repeat (10) @(posedge clk);
    #1;
    clr = 1'b1;
    @(negedge clk);
    check("clr_stall", {31'd0, stall_req}, 32'd0);
    @(posedge clk);
    #1;
    clr       = 1'b0;
    div_start = 1'b0;
    check("clr_valid", {31'd0, result_valid}, 32'd0);
    check("clr_lo_held", lo, last_lo);
    check("clr_hi_held", hi, last_hi);
    @(negedge clk);
    check("clr_idle_stall", {31'd0, stall_req}, 32'd0);
    @(posedge clk);
    #1;
    do_div("after_clr", 1'b1, 32'hFFFF_F000, 32'd9, 1'b0);

    // Asynchronous reset between edges in the middle of BUSY.
    div_start = 1'b1;
    dividend  = 32'd999;
    divisor   = 32'd4;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_lo", lo, 32'd0);
    check("arst_hi", hi, 32'd0);
    check("arst_valid", {31'd0, result_valid}, 32'd0);
    div_start = 1'b0;
    #1;
    check("arst_stall", {31'd0, stall_req}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_div("after_arst", 1'b0, 32'd1000, 32'd10, 1'b0);

    // Back-to-back: start held through DONE must not retrigger.
    do_div("b2b_first", 1'b0, 32'hFFFF_FFFF, 32'd1, 1'b1);
    do_div("b2b_second", 1'b0, 32'd10, 32'd3, 1'b0);

    // Randomized divides.
    for (int i = 0; i < 20; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 255));
        2:       rb = {28'hFFFF_FFF, 4'($urandom)};
        default: rb = $urandom;
      endcase
      do_div("rand", rs, ra, rb, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
